mips_int_timer: RTL and testbench
=================================

Name: mips_int_timer

Overview:
- Memory-mapped programmable timer that generates the `int0` interrupt request consumed by `mips_cpu`.
- It is the interrupt-source end of the CPU's `int0` interface. It counts prescaled clock ticks, raises a sticky pending flag on expiry, and drives `int0` until software clears the flag or the CPU acknowledges it.
- Sits on the CPU data-memory bus beside data RAM, selected by address decode outside this block.

Parameters:
- DATA_W, 32, bus data width.
- CNT_W, 32, counter and LOAD register width (must be ≤ DATA_W).
- PRESCALE, 4, clock cycles per timer tick (≥ 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset.
- sel  input  1  bus select for this block.
- we  input  1  write strobe, qualified by `sel`.
- addr  input  2  word index: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  read data, combinational from `addr`.
- int_ack  input  1  single-cycle pulse from the CPU on interrupt entry.
- int0  output  1  registered interrupt request to `mips_cpu`.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - CTRL, LOAD, COUNT, STATUS, prescaler and FSM all cleared; FSM to IDLE.
  - `int0`=0.
  - Reset asserted mid-count aborts immediately; no interrupt is generated.
- CTRL[0] EN, CTRL[1] AUTO (auto-reload), CTRL[2] IE (interrupt enable). Other CTRL bits read 0.
- STATUS[0] PEND:
  - Sticky.
  - Software write of 1 clears it; write of 0 has no effect.
- COUNT is read-only; writes to it are ignored.
- Unused high `rdata` bits read 0.
- Prescaler:
  - Counts 0..PRESCALE-1 while the FSM is in RUN.
  - A tick occurs on the cycle it wraps to 0.
  - Cleared whenever the FSM enters RUN.
- FSM:
  - IDLE: on a CTRL write with EN=1, set COUNT=LOAD, clear the prescaler, go to RUN.
  - RUN, on tick with COUNT≠0: COUNT decrements by 1.
  - RUN, on tick with COUNT=0 (expiry): set PEND.
    - If AUTO=1: COUNT=LOAD, stay in RUN.
    - If AUTO=0: go to DONE and clear EN in hardware.
  - RUN, on CTRL write with EN=0: go to IDLE. COUNT holds its value; PEND is unchanged.
  - DONE: on CTRL write with EN=1, reload COUNT=LOAD and go to RUN.
- Period:
  - (LOAD+1)*PRESCALE cycles from the enable write to the first PEND set.
  - The same period applies between auto-reload expiries.
  - LOAD=0 expires on every tick.
- LOAD writes during RUN do not disturb COUNT; they take effect at the next reload.
- `int0` is registered as PEND & IE, so it is asserted 1 cycle after PEND sets.
- Clearing IE deasserts `int0` next cycle but keeps PEND.
- `int_ack`=1 clears PEND.
- Simultaneous events:
  - Expiry and `int_ack` (or a STATUS clear write) in the same cycle: set wins, PEND stays 1 and the new event is not lost.
  - CTRL write with EN=0 and expiry in the same cycle: the write wins, no PEND set.
  - A CTRL write with EN=1 while already in RUN restarts the count from LOAD.
- COUNT wrap-around never occurs: the counter is reloaded at 0, never decremented below 0.

Test Plan:
- Reset check:
  - Stimulus: hold `rst`=0 for 4 cycles, release, read all four registers.
  - Required: all read 0; `int0`=0.
- One-shot:
  - Stimulus: PRESCALE=4, write LOAD=3, then CTRL=0x5 (EN, IE).
  - Required: PEND sets 16 cycles after the write and `int0` rises 1 cycle later. CTRL reads 0x4 afterwards (EN cleared by hardware) and COUNT reads 0.
- Auto-reload with acknowledge:
  - Stimulus: LOAD=1, CTRL=0x7; pulse `int_ack` 2 cycles after each `int0` rise.
  - Required: `int0` rises every 8 cycles for 5 periods, falling 1 cycle after each ack.
- Simultaneous clear and expiry:
  - Stimulus: LOAD=0, CTRL=0x7; write STATUS=1 on an expiry cycle.
  - Required: PEND remains 1 and `int0` stays high.
- Masking and stop:
  - Stimulus: let PEND set with IE=0; confirm `int0`=0. Set IE, then write CTRL=0 mid-count.
  - Required: `int0` rises 1 cycle after the IE write; COUNT freezes; no further PEND set after software clears it.
- Asynchronous reset mid-run:
  - Stimulus: drop `rst` between clock edges while COUNT=2.
  - Required: `int0` and COUNT go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_int_timer.sv
// Memory-mapped programmable timer: prescaled down-counter with sticky pending flag
// driving the registered int0 request to mips_cpu.
module mips_int_timer #(
  parameter int DATA_W   = 32,
  parameter int CNT_W    = 32,
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic              we,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              int_ack,
  output logic              int0
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              en, auto_rl, ie, pend;
  logic [CNT_W-1:0]  load, count;
  logic [PS_W-1:0]   presc;

  logic              bus_wr, ctrl_wr, load_wr, stat_clr;
  logic              tick, cnt_zero;
  logic              reload, dec, expire, clr_en;

  assign bus_wr   = sel & we;
  assign ctrl_wr  = bus_wr && (addr == 2'd0);
  assign load_wr  = bus_wr && (addr == 2'd1);
  assign stat_clr = bus_wr && (addr == 2'd3) && wdata[0];
  assign tick     = (state == RUN) && (presc == PS_LAST);
  assign cnt_zero = (count == '0);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (ctrl_wr && wdata[0]) state_nxt = RUN;
      RUN: begin
        if (ctrl_wr)                        state_nxt = wdata[0] ? RUN : IDLE;
        else if (tick && cnt_zero && !auto_rl) state_nxt = DONE;
      end
      default:                               state_nxt = IDLE;
    endcase
  end

  // A CTRL write always beats a same-cycle expiry, so a stop never leaves PEND set.
  always_comb begin
    reload = 1'b0;
    dec    = 1'b0;
    expire = 1'b0;
    clr_en = 1'b0;
    case (state)
      IDLE, DONE: reload = ctrl_wr && wdata[0];
      RUN: begin
        if (ctrl_wr) begin
          reload = wdata[0];
        end else if (tick) begin
          if (cnt_zero) begin
            expire = 1'b1;
            reload = auto_rl;
            clr_en = !auto_rl;
          end else begin
            dec = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en      <= 1'b0;
      auto_rl <= 1'b0;
      ie      <= 1'b0;
      load    <= '0;
      count   <= '0;
      presc   <= '0;
      pend    <= 1'b0;
      int0    <= 1'b0;
    end else begin
      if (ctrl_wr)     {ie, auto_rl, en} <= wdata[2:0];
      else if (clr_en) en <= 1'b0;

      if (load_wr) load <= wdata[CNT_W-1:0];

      if (reload)   count <= load;
      else if (dec) count <= count - CNT_W'(1);

      if (reload)              presc <= '0;
      else if (state == RUN)   presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);

      // Set has priority so an expiry coinciding with a clear is not lost.
      if (expire)                   pend <= 1'b1;
      else if (stat_clr || int_ack) pend <= 1'b0;

      int0 <= pend & ie;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'd0: rdata[2:0]       = {ie, auto_rl, en};
      2'd1: rdata[CNT_W-1:0] = load;
      2'd2: rdata[CNT_W-1:0] = count;
      2'd3: rdata[0]         = pend;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mips_int_timer.sv
// Self-checking bench for mips_int_timer: directed scenarios plus a random bus/ack
// phase, all compared against an elapsed-time model of the timer.
module tb_mips_int_timer;

  localparam int P = 4;

  logic        clk = 1'b0, rst = 1'b0, sel = 1'b0, we = 1'b0, int_ack = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = 32'd0, rdata;
  logic        int0;

  int n_pass = 0, n_total = 0;

  mips_int_timer #(.DATA_W(32), .CNT_W(32), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .int_ack(int_ack), .int0(int0)
  );

  always #10 clk = ~clk;

  // Reference model: time since the last (re)load determines COUNT and expiry.
  bit          m_run, m_en, m_auto, m_ie, m_pend, m_int0;
  int unsigned m_load, m_base, m_elapsed, m_hold;

  function automatic int unsigned m_count();
    return m_run ? m_base - m_elapsed / P : m_hold;
  endfunction

  task automatic model_reset();
    m_run = 0; m_en = 0; m_auto = 0; m_ie = 0; m_pend = 0; m_int0 = 0;
    m_load = 0; m_base = 0; m_elapsed = 0; m_hold = 0;
  endtask

  task automatic model_edge(input bit s, input bit w, input logic [1:0] a,
                            input logic [31:0] d, input bit ack);
    bit wr, expire_now, nxt_int0;
    int unsigned cur;
    wr         = s && w;
    cur        = m_count();
    nxt_int0   = m_pend && m_ie;
    expire_now = 0;
    if (wr && a == 2'd0) begin
      m_en = d[0]; m_auto = d[1]; m_ie = d[2];
      if (d[0]) begin
        m_run = 1; m_base = m_load; m_elapsed = 0;
      end else if (m_run) begin
        m_run = 0; m_hold = cur;
      end
    end else if (m_run) begin
      if (m_elapsed + 1 == (m_base + 1) * P) begin
        expire_now = 1;
        if (m_auto) begin
          m_base = m_load; m_elapsed = 0;
        end else begin
          m_run = 0; m_en = 0; m_hold = 0;
        end
      end else begin
        m_elapsed++;
      end
    end
    if ((wr && a == 2'd3 && d[0]) || ack) m_pend = 0;
    if (expire_now) m_pend = 1;
    if (wr && a == 2'd1) m_load = d;
    m_int0 = nxt_int0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input bit s = 0, input bit w = 0, input logic [1:0] a = 2'd0,
                      input logic [31:0] d = 32'd0, input bit ack = 0);
    @(negedge clk);
    sel = s; we = w; addr = a; wdata = d; int_ack = ack;
    @(posedge clk);
    model_edge(s, w, a, d, ack);
    #1;
    sel = 0; we = 0; int_ack = 0;
    check("int0", {31'b0, int0}, {31'b0, m_int0});
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    step(1, 1, a, d, 0);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic check_regs();
    logic [31:0] v;
    rd(2'd0, v); check("ctrl",   v, {29'b0, m_ie, m_auto, m_en});
    rd(2'd1, v); check("load",   v, m_load);
    rd(2'd2, v); check("count",  v, m_count());
    rd(2'd3, v); check("status", v, {31'b0, m_pend});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    model_reset();
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    model_edge(0, 0, 2'd0, 32'd0, 0);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int first_pend, first_int0, ack_at;
    bit prev, s, w, ack;
    logic [1:0] a;
    logic [31:0] d;
    int rises[$];
    int falls[$];

    // Reset state
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rd(2'(i), v);
      check($sformatf("reset_reg%0d", i), v, 32'd0);
    end
    check("reset_int0", {31'b0, int0}, 32'd0);

    // One-shot: LOAD=3, EN|IE
    wr_reg(2'd1, 32'd3);
    wr_reg(2'd0, 32'h5);
    first_pend = -1; first_int0 = -1;
    for (int k = 1; k <= 24; k++) begin
      step();
      rd(2'd3, v);
      if (v[0] && first_pend < 0) first_pend = k;
      if (int0 && first_int0 < 0) first_int0 = k;
    end
    check("oneshot_pend_delay", 32'(first_pend), 32'd16);
    check("oneshot_int0_delay", 32'(first_int0), 32'd17);
    check_regs();
    rd(2'd0, v); check("oneshot_ctrl", v, 32'h4);
    rd(2'd2, v); check("oneshot_count", v, 32'd0);

    // Auto-reload with acknowledge two cycles after each rise
    do_reset();
    wr_reg(2'd1, 32'd1);
    wr_reg(2'd0, 32'h7);
    prev = 0; ack_at = -1;
    for (int k = 1; k <= 56; k++) begin
      step(0, 0, 2'd0, 32'd0, k == ack_at);
      if (int0 && !prev) begin
        rises.push_back(k);
        ack_at = k + 2;
      end
      if (!int0 && prev) falls.push_back(k);
      prev = int0;
    end
    check("ar_rise_count", 32'(rises.size()), 32'd6);
    check("ar_fall_count", 32'(falls.size()), 32'd6);
    if (rises.size() > 0) check("ar_first_rise", 32'(rises[0]), 32'd9);
    for (int i = 1; i < rises.size(); i++)
      check($sformatf("ar_period%0d", i), 32'(rises[i] - rises[i-1]), 32'd8);
    for (int i = 0; i < rises.size() && i < falls.size(); i++)
      check($sformatf("ar_fall%0d", i), 32'(falls[i] - rises[i]), 32'd3);

    // STATUS clear coinciding with an expiry
    do_reset();
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd0, 32'h7);
    repeat (7) step();
    wr_reg(2'd3, 32'd1);
    rd(2'd3, v); check("simul_pend", v, 32'd1);
    check("simul_int0_a", {31'b0, int0}, 32'd1);
    step();
    check("simul_int0_b", {31'b0, int0}, 32'd1);
    wr_reg(2'd3, 32'd1);
    rd(2'd3, v); check("plain_clear_pend", v, 32'd0);
    step();
    check("plain_clear_int0", {31'b0, int0}, 32'd0);

    // Masking, late IE, then stop mid-count
    do_reset();
    wr_reg(2'd1, 32'd2);
    wr_reg(2'd0, 32'h3);
    repeat (14) step();
    rd(2'd3, v); check("mask_pend", v, 32'd1);
    check("mask_int0_low", {31'b0, int0}, 32'd0);
    wr_reg(2'd0, 32'h7);
    check("mask_int0_at_ie_write", {31'b0, int0}, 32'd0);
    step();
    check("mask_int0_rise", {31'b0, int0}, 32'd1);
    wr_reg(2'd3, 32'd1);
    step();
    step();
    wr_reg(2'd0, 32'h0);
    rd(2'd2, v); check("stop_count", v, 32'd1);
    repeat (20) step();
    rd(2'd2, v); check("stop_count_frozen", v, 32'd1);
    rd(2'd3, v); check("stop_no_pend", v, 32'd0);
    check("stop_int0", {31'b0, int0}, 32'd0);

    // Asynchronous reset while COUNT=2 with int0 high
    do_reset();
    wr_reg(2'd1, 32'd0);
    wr_reg(2'd0, 32'h7);
    repeat (3) step();
    wr_reg(2'd1, 32'd3);
    repeat (9) step();
    rd(2'd2, v); check("areset_pre_count", v, 32'd2);
    check("areset_pre_int0", {31'b0, int0}, 32'd1);
    rst = 0;
    #1;
    check("areset_int0", {31'b0, int0}, 32'd0);
    rd(2'd2, v); check("areset_count", v, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    model_edge(0, 0, 2'd0, 32'd0, 0);
    #1;

    // Random bus traffic and acknowledges against the model
    do_reset();
    for (int i = 0; i < 500; i++) begin
      s   = ($urandom_range(0, 3) == 0);
      w   = 1'($urandom_range(0, 1));
      a   = 2'($urandom_range(0, 3));
      d   = (a == 2'd1) ? 32'($urandom_range(0, 5)) : 32'($urandom());
      ack = ($urandom_range(0, 15) == 0);
      step(s, w, a, d, ack);
      check_regs();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
